nco_mixer: RTL and testbench

NCO_MIXER -- requirements
Module: nco_mixer

---
 rtl/nco_mixer.sv | 140 ++++++++++++++
 tb/tb_nco_mixer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nco_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nco_mixer : complex sample x NCO phasor mixer, 3-stage elastic pipeline  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module nco_mixer #(
   parameter bit CONJ = 1'b0
) (
   input  logic        clk,
   input  logic        srst,
   input  logic [31:0] i_nco_data,
   input  logic        i_nco_valid,
   output logic        i_nco_ready,
   input  logic [31:0] i_samp_data,
   input  logic        i_samp_valid,
   output logic        i_samp_ready,
   input  logic        flush,
   output logic [31:0] o_data,
   output logic        o_valid,
   input  logic        o_ready,
   output logic        busy
);

   logic               adv;
   logic               accept;
   logic signed [15:0] a, b, c, s;
   logic signed [31:0] ac_w, bs_w, as_w, bc_w;
   logic signed [32:0] sum_i_w, sum_q_w;

   logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic signed [31:0] ac_q, ac_d, bs_q, bs_d, as_q, as_d, bc_q, bc_d;
   logic signed [32:0] i_q, i_d, q_q, q_d;
   logic [31:0]        data_q, data_d;

   // Round half up at bit 15, then clamp into the Q1.15 range.
   function automatic logic [15:0] sat_round(input logic signed [32:0] v);
      logic signed [33:0] t;
      t = (34'(v) + 34'sd16384) >>> 15;
      if (t > 34'sd32767)
         sat_round = 16'h7FFF;
      else if (t < -34'sd32768)
         sat_round = 16'h8000;
      else
         sat_round = t[15:0];
   endfunction

   assign a = i_samp_data[15:0];
   assign b = i_samp_data[31:16];
   assign c = i_nco_data[15:0];
   assign s = i_nco_data[31:16];

   assign ac_w = a * c;
   assign bs_w = b * s;
   assign as_w = a * s;
   assign bc_w = b * c;

   assign adv          = !v3_q || o_ready;
   assign accept       = i_nco_valid && i_samp_valid && adv && !flush && !srst;
   assign i_nco_ready  = accept;
   assign i_samp_ready = accept;

   generate
      if (CONJ) begin : g_conj
         assign sum_i_w = 33'(ac_q) + 33'(bs_q);
         assign sum_q_w = 33'(bc_q) - 33'(as_q);
      end else begin : g_direct
         assign sum_i_w = 33'(ac_q) - 33'(bs_q);
         assign sum_q_w = 33'(as_q) + 33'(bc_q);
      end
   endgenerate

   always_comb begin
      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      ac_d   = ac_q;
      bs_d   = bs_q;
      as_d   = as_q;
      bc_d   = bc_q;
      i_d    = i_q;
      q_d    = q_q;
      data_d = data_q;
      if (adv) begin
         v1_d = accept;
         v2_d = v1_q;
         v3_d = v2_q;
         if (accept) begin
            ac_d = ac_w;
            bs_d = bs_w;
            as_d = as_w;
            bc_d = bc_w;
         end
         if (v1_q) begin
            i_d = sum_i_w;
            q_d = sum_q_w;
         end
         if (v2_q) begin
            data_d = {sat_round(q_q), sat_round(i_q)};
         end
      end
      // Flush drops every stage regardless of downstream backpressure.
      if (flush) begin
         v1_d = 1'b0;
         v2_d = 1'b0;
         v3_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         ac_q   <= '0;
         bs_q   <= '0;
         as_q   <= '0;
         bc_q   <= '0;
         i_q    <= '0;
         q_q    <= '0;
         data_q <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         ac_q   <= ac_d;
         bs_q   <= bs_d;
         as_q   <= as_d;
         bc_q   <= bc_d;
         i_q    <= i_d;
         q_q    <= q_d;
         data_q <= data_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = v3_q;
   assign busy    = v1_q || v2_q || v3_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nco_mixer : self-checking bench for nco_mixer (CONJ=0 and CONJ=1)     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_nco_mixer;

   logic        clk;
   logic        srst;
   logic [31:0] nco_data, samp_data;
   logic        nco_valid, samp_valid, flush, o_ready;
   logic        nco_rdy0, samp_rdy0, ov0, busy0;
   logic        nco_rdy1, samp_rdy1, ov1, busy1;
   logic [31:0] od0, od1;

   int checks   = 0;
   int failures = 0;
   int incnt    = 0;
   int outcnt   = 0;

   bit          mv [1:3];
   logic [31:0] md0 [1:3];
   logic [31:0] md1 [1:3];

   nco_mixer #(.CONJ(1'b0)) dut0 (
      .clk(clk), .srst(srst),
      .i_nco_data(nco_data), .i_nco_valid(nco_valid), .i_nco_ready(nco_rdy0),
      .i_samp_data(samp_data), .i_samp_valid(samp_valid), .i_samp_ready(samp_rdy0),
      .flush(flush), .o_data(od0), .o_valid(ov0), .o_ready(o_ready), .busy(busy0)
   );

   nco_mixer #(.CONJ(1'b1)) dut1 (
      .clk(clk), .srst(srst),
      .i_nco_data(nco_data), .i_nco_valid(nco_valid), .i_nco_ready(nco_rdy1),
      .i_samp_data(samp_data), .i_samp_valid(samp_valid), .i_samp_ready(samp_rdy1),
      .flush(flush), .o_data(od1), .o_valid(ov1), .o_ready(o_ready), .busy(busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] qnt(input longint v);
      longint r;
      r = v + 16384;
      r = (r >= 0) ? r / 32768 : -((-r + 32767) / 32768);
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   // Ideal complex multiply: (a+jb)*(c+js), or by (c-js) when conj is set.
   function automatic logic [31:0] mix(input logic [31:0] smp, input logic [31:0] nco, input bit conj);
      longint a, b, c, s, ri, rq;
      a = longint'($signed(smp[15:0]));
      b = longint'($signed(smp[31:16]));
      c = longint'($signed(nco[15:0]));
      s = longint'($signed(nco[31:16]));
      if (!conj) begin
         ri = a * c - b * s;
         rq = a * s + b * c;
      end else begin
         ri = a * c + b * s;
         rq = b * c - a * s;
      end
      return {qnt(rq), qnt(ri)};
   endfunction

   // Cycle model: three slots of expected outputs, advancing by the handshake rules.
   initial begin
      bit adv, acc;
      for (int k = 1; k <= 3; k++) begin
         mv[k] = 1'b0; md0[k] = '0; md1[k] = '0;
      end
      forever begin
         @(negedge clk);
         if (srst) begin
            for (int k = 1; k <= 3; k++) mv[k] = 1'b0;
            md0[3] = '0; md1[3] = '0;
            chk("rst_ovalid", {30'd0, ov1, ov0}, 32'd0);
            chk("rst_busy", {30'd0, busy1, busy0}, 32'd0);
            chk("rst_ready", {28'd0, nco_rdy1, samp_rdy1, nco_rdy0, samp_rdy0}, 32'd0);
            chk("rst_odata0", od0, 32'd0);
            chk("rst_odata1", od1, 32'd0);
         end else begin
            adv = !mv[3] || o_ready;
            acc = nco_valid && samp_valid && adv && !flush;
            chk("ready", {28'd0, nco_rdy1, samp_rdy1, nco_rdy0, samp_rdy0}, acc ? 32'hF : 32'h0);
            chk("ovalid", {30'd0, ov1, ov0}, mv[3] ? 32'd3 : 32'd0);
            chk("busy", {30'd0, busy1, busy0}, (mv[1] || mv[2] || mv[3]) ? 32'd3 : 32'd0);
            if (mv[3]) begin
               chk("odata0", od0, md0[3]);
               chk("odata1", od1, md1[3]);
               if (o_ready) outcnt++;
            end
            if (acc) incnt++;
            if (adv) begin
               mv[3] = mv[2]; md0[3] = mv[2] ? md0[2] : md0[3]; md1[3] = mv[2] ? md1[2] : md1[3];
               mv[2] = mv[1]; md0[2] = md0[1]; md1[2] = md1[1];
               mv[1] = acc;
               if (acc) begin
                  md0[1] = mix(samp_data, nco_data, 1'b0);
                  md1[1] = mix(samp_data, nco_data, 1'b1);
               end
            end
            if (flush) for (int k = 1; k <= 3; k++) mv[k] = 1'b0;
         end
      end
   end

   // One isolated pair into an idle pipeline; result must appear exactly 3 edges after accept.
   task automatic run_pair(input logic [31:0] smp, input logic [31:0] nco,
                           input logic [31:0] exp0, input logic [31:0] exp1);
      @(posedge clk); #1;
      samp_data = smp; nco_data = nco; samp_valid = 1'b1; nco_valid = 1'b1;
      @(posedge clk); #1;
      samp_valid = 1'b0; nco_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("lat_ovalid", {30'd0, ov1, ov0}, 32'd3);
      chk("pair_conj0", od0, exp0);
      chk("pair_conj1", od1, exp1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int i0, o0, cyc;
      srst = 1'b1; flush = 1'b0; o_ready = 1'b1;
      nco_valid = 1'b0; samp_valid = 1'b0; nco_data = '0; samp_data = '0;

      chk("model_unity", mix(32'h0000_4000, 32'h0000_7FFF, 1'b0), 32'h0000_4000);
      chk("model_sat", mix(32'h0000_8000, 32'h0000_8000, 1'b0), 32'h0000_7FFF);
      chk("model_conj1", mix(32'h4000_0000, 32'h4000_0000, 1'b1), 32'h0000_2000);
      chk("model_conj0", mix(32'h4000_0000, 32'h4000_0000, 1'b0), 32'h0000_E000);

      repeat (3) @(posedge clk);
      #1 srst = 1'b0;

      run_pair(32'h0000_4000, 32'h0000_7FFF, 32'h0000_4000, 32'h0000_4000);
      run_pair(32'h0000_8000, 32'h0000_8000, 32'h0000_7FFF, 32'h0000_7FFF);
      run_pair(32'h4000_0000, 32'h4000_0000, 32'h0000_E000, 32'h0000_2000);
      run_pair(32'h0000_4000, 32'h4000_0000, 32'h2000_0000, 32'hE000_0000);

      // Join: phasor alone must not be consumed.
      @(posedge clk); #1;
      nco_valid = 1'b1; nco_data = 32'h1234_5678;
      repeat (5) @(posedge clk);
      #1 chk("join_noconsume_busy", {31'd0, busy0}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         samp_valid = 1'b1; nco_valid = 1'b1;
         samp_data = 32'h0100_0300 + 32'(k * 32'h0101_0101);
         nco_data  = 32'h2000_6000 - 32'(k * 32'h0300_0500);
         @(posedge clk); #1;
      end
      samp_valid = 1'b0; nco_valid = 1'b0;
      o_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, ov0}, 32'd1);
      chk("bp_hold_data", od0, mix(32'h0100_0300 + 32'h0101_0101, 32'h2000_6000 - 32'h0300_0500, 1'b0));
      o_ready = 1'b1;
      repeat (6) @(posedge clk);

      // Randomised traffic with backpressure; every pair must emerge once, in order.
      #1;
      i0 = incnt; o0 = outcnt; cyc = 0;
      while ((incnt - i0) < 100 && cyc < 3000) begin
         nco_valid  = ($urandom % 4) != 0;
         samp_valid = ($urandom % 4) != 0;
         o_ready    = ($urandom % 5) != 0;
         nco_data   = $urandom;
         samp_data  = $urandom;
         @(posedge clk); #1;
         cyc++;
      end
      chk("random_pairs_accepted", 32'(incnt - i0), 32'd100);
      nco_valid = 1'b0; samp_valid = 1'b0; o_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("random_count", 32'(outcnt - o0), 32'(incnt - i0));

      // Flush with three pairs in flight and output stalled.
      o_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         samp_valid = 1'b1; nco_valid = 1'b1;
         samp_data = 32'h7FFF_0000 + 32'(k); nco_data = 32'h0000_7FFF - 32'(k);
         @(posedge clk); #1;
      end
      chk("flush_pre_busy", {30'd0, busy1, busy0}, 32'd3);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; samp_valid = 1'b0; nco_valid = 1'b0;
      chk("flush_ovalid", {30'd0, ov1, ov0}, 32'd0);
      chk("flush_busy", {30'd0, busy1, busy0}, 32'd0);
      o_ready = 1'b1;
      repeat (3) @(posedge clk);

      // Asynchronous reset mid-stream.
      #1;
      for (int k = 0; k < 3; k++) begin
         samp_valid = 1'b1; nco_valid = 1'b1;
         samp_data = 32'h0123_4567 + 32'(k); nco_data = 32'h7654_3210 - 32'(k);
         @(posedge clk); #1;
      end
      srst = 1'b1;
      #1;
      chk("srst_ovalid", {30'd0, ov1, ov0}, 32'd0);
      chk("srst_busy", {30'd0, busy1, busy0}, 32'd0);
      chk("srst_odata", od0, 32'd0);
      chk("srst_ready", {30'd0, nco_rdy0, samp_rdy0}, 32'd0);
      @(posedge clk); #1;
      srst = 1'b0;
      #1 chk("post_srst_ready", {30'd0, nco_rdy0, samp_rdy0}, 32'd3);
      @(posedge clk); #1;
      samp_valid = 1'b0; nco_valid = 1'b0;
      repeat (6) @(posedge clk);

      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
